// File: rtl/crack_key_scheduler.sv
// crack_key_scheduler
//   Hands out candidate ARC4 keys 0..KEY_MAX in ascending order to a pool of NCORES crack
//   cores, one key per core per job, and stops the search on the first key a core reports
//   as yielding printable plaintext.
//
// Optional feature (compile-time macro CRACK_SCHED_ABORT_EN):
//   Adds output core_abort. In the cycle a find is latched, every other in-flight core is
//   told to abort so the drain finishes quickly. Aborted cores' core_found is ignored.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          start pulse, honoured only while rdy=1
//   rdy         idle and ready to accept en
//   key         winning key (0 when exhausted), held until the next accepted en
//   key_valid   1 = key found, 0 = key space exhausted; held until the next accepted en
//   core_en     one-cycle start pulse per core
//   core_key    candidate key per core, slice i = bits [i*KEY_W +: KEY_W]
//   core_rdy    per-core idle/finished
//   core_found  per-core result, valid while core_rdy=1 after a job
//   core_abort  (CRACK_SCHED_ABORT_EN only) per-core abort pulse
module crack_key_scheduler #(
  parameter int unsigned      NCORES  = 2,
  parameter int unsigned      KEY_W   = 24,
  parameter logic [KEY_W-1:0] KEY_MAX = 24'hFFFFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    rdy,
  output logic [KEY_W-1:0]        key,
  output logic                    key_valid,
  output logic [NCORES-1:0]       core_en,
  output logic [NCORES*KEY_W-1:0] core_key,
  input  logic [NCORES-1:0]       core_rdy,
  input  logic [NCORES-1:0]       core_found
`ifdef CRACK_SCHED_ABORT_EN
  ,
  output logic [NCORES-1:0]       core_abort
`endif
);

  localparam int unsigned IdxW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {StIdle, StDispatch, StDrain} state_e;

  state_e state_q, state_d;

  logic [NCORES-1:0]            busy_q, busy_d;
  // Core was started last cycle; its core_rdy has not dropped yet and must not count.
  logic [NCORES-1:0]            just_q;
  // One extra bit so issuing KEY_MAX = all-ones cannot wrap the compare.
  logic [KEY_W:0]               next_q, next_d;
  logic [KEY_W-1:0]             key_q, key_d;
  logic                         valid_q, valid_d;
  logic [NCORES-1:0][KEY_W-1:0] ckey_q, ckey_d;

  logic [NCORES-1:0] complete, hits, eligible;
  logic              find, disp, last_issue;
  logic [IdxW-1:0]   find_idx, disp_idx;

  assign complete   = busy_q & core_rdy & ~just_q;
  assign hits       = complete & core_found;
  assign find       = ~valid_q & (|hits);
  // A core finishing this cycle is still busy, so it is only eligible next cycle.
  assign eligible   = ~busy_q & core_rdy;
  // No dispatch in the cycle a find is latched: the search is over.
  assign disp       = (state_q == StDispatch) & ~find & (|eligible);
  assign last_issue = disp & (next_q == {1'b0, KEY_MAX});

  // Lowest index wins for both the find and the dispatch target.
  always_comb begin
    find_idx = '0;
    disp_idx = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (hits[i]) find_idx = IdxW'(i);
      if (eligible[i]) disp_idx = IdxW'(i);
    end
  end

  // Datapath next-state.
  always_comb begin
    busy_d  = busy_q & ~complete;
    ckey_d  = ckey_q;
    next_d  = next_q;
    key_d   = key_q;
    valid_d = valid_q;
    if (disp) begin
      busy_d[disp_idx] = 1'b1;
      ckey_d[disp_idx] = next_q[KEY_W-1:0];
      next_d           = next_q + (KEY_W + 1)'(1);
    end
    if (find) begin
      key_d   = ckey_q[find_idx];
      valid_d = 1'b1;
    end
    if ((state_q == StIdle) && en) begin
      next_d  = '0;
      key_d   = '0;
      valid_d = 1'b0;
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (en) state_d = StDispatch;
      end
      StDispatch: begin
        if (find || last_issue) state_d = (busy_d == '0) ? StIdle : StDrain;
      end
      StDrain: begin
        if (busy_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    rdy       = (state_q == StIdle);
    key       = key_q;
    key_valid = valid_q;
    core_en   = '0;
    if (disp) core_en[disp_idx] = 1'b1;
    // The dispatched slice shows its new key in the same cycle as its core_en.
    core_key  = ckey_d;
`ifdef CRACK_SCHED_ABORT_EN
    core_abort = find ? (busy_q & ~complete) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      just_q  <= '0;
      next_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      ckey_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      just_q  <= core_en;
      next_q  <= next_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      ckey_q  <= ckey_d;
    end
  end

endmodule

// File: tb/tb_crack_key_scheduler.sv
// Testbench for crack_key_scheduler: behavioural crack cores plus a cycle-level reference
// model of the scheduling rules; every cycle the DUT outputs are compared with the model.
module tb_crack_key_scheduler;

  localparam int unsigned   NC    = 2;
  localparam int unsigned   KW    = 24;
  localparam logic [KW-1:0] KMAX  = 24'h00003F;
  localparam int            NKEYS = 64;

  logic            clk = 1'b0;
  logic            rst_n, en;
  logic            rdy, key_valid;
  logic [KW-1:0]   key;
  logic [NC-1:0]   core_en, core_rdy, core_found;
  logic [NC*KW-1:0] core_key;
`ifdef CRACK_SCHED_ABORT_EN
  logic [NC-1:0]   core_abort;
`endif

  crack_key_scheduler #(.NCORES(NC), .KEY_W(KW), .KEY_MAX(KMAX)) dut (
`ifdef CRACK_SCHED_ABORT_EN
    .core_abort(core_abort),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rdy(rdy),
    .key(key),
    .key_valid(key_valid),
    .core_en(core_en),
    .core_key(core_key),
    .core_rdy(core_rdy),
    .core_found(core_found)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state.
  int m_state;  // 0 idle, 1 dispatching, 2 draining
  bit m_busy[NC];
  bit m_just[NC];
  int m_ckey[NC];
  int m_next, m_key;
  bit m_valid;

  // Model outputs for the current cycle.
  bit              e_comp[NC];
  bit              e_find, e_disp;
  int              e_fidx, e_didx;
  logic [NC-1:0]   e_en, e_abort;
  logic [NC*KW-1:0] e_ckey_v;

  // Behavioural cores.
  int c_start[NC], c_done[NC];
  bit c_res[NC];
  int lat_fixed[NC];
  bit cores_off;
  int fk0, fk1, p_found, en_pct;

  // Observations of the DUT.
  typedef struct {int c; int core; int k;} disp_t;
  disp_t dlog[$];
  int issued[NKEYS];
  int n_issued, max_issued, above_max, abort_cnt, abort_cyc, rdy_cyc, job_cyc;
  logic [NC-1:0] abort_val;
  bit seen_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_next  = 0;
    m_key   = 0;
    m_valid = 0;
    for (int c = 0; c < NC; c++) begin
      m_busy[c] = 0;
      m_just[c] = 0;
      m_ckey[c] = 0;
    end
  endtask

  task automatic core_reset();
    for (int c = 0; c < NC; c++) begin
      c_start[c] = -10;
      c_done[c]  = -10;
      c_res[c]   = 0;
    end
  endtask

  task automatic clear_obs();
    dlog.delete();
    for (int k = 0; k < NKEYS; k++) issued[k] = 0;
    n_issued   = 0;
    max_issued = -1;
    above_max  = 0;
    abort_cnt  = 0;
    abort_cyc  = -1;
    abort_val  = '0;
    rdy_cyc    = -1;
    seen_busy  = 0;
  endtask

  // Core stays ready for one cycle after its start, then is busy until c_done.
  task automatic drive_cores();
    for (int c = 0; c < NC; c++) begin
      bit r, f;
      r = !cores_off && ((cyc <= c_start[c] + 1) || (cyc >= c_done[c]));
      if (!cores_off && cyc >= c_done[c]) f = c_res[c];
      else if (r) f = core_found[c];
      else f = 1'($urandom_range(0, 1));
      core_rdy[c]   = r;
      core_found[c] = f;
    end
  endtask

  task automatic model_eval();
    e_find  = 0;
    e_fidx  = 0;
    e_disp  = 0;
    e_didx  = 0;
    e_en    = '0;
    e_abort = '0;
    for (int c = 0; c < NC; c++) e_comp[c] = m_busy[c] && core_rdy[c] && !m_just[c];
    if (!m_valid) begin
      for (int c = 0; c < NC; c++) begin
        if (!e_find && e_comp[c] && core_found[c]) begin
          e_find = 1;
          e_fidx = c;
        end
      end
    end
    if (m_state == 1 && !e_find) begin
      for (int c = 0; c < NC; c++) begin
        if (!e_disp && !m_busy[c] && core_rdy[c]) begin
          e_disp = 1;
          e_didx = c;
        end
      end
    end
    if (e_disp) e_en[e_didx] = 1'b1;
    for (int c = 0; c < NC; c++)
      e_ckey_v[c*KW +: KW] = (e_disp && c == e_didx) ? KW'(m_next) : KW'(m_ckey[c]);
    if (e_find) begin
      for (int c = 0; c < NC; c++) e_abort[c] = m_busy[c] && !e_comp[c];
    end
  endtask

  task automatic compare();
    check("rdy", rdy, (m_state == 0));
    check("key", key, m_key);
    check("key_valid", key_valid, m_valid);
    check("core_en", core_en, e_en);
    check("core_key", core_key, e_ckey_v);
`ifdef CRACK_SCHED_ABORT_EN
    check("core_abort", core_abort, e_abort);
    if (core_abort != '0) begin
      abort_cnt++;
      abort_val = core_abort;
      abort_cyc = cyc;
    end
`endif
    for (int c = 0; c < NC; c++) begin
      if (core_en[c]) begin
        int k;
        k = int'(core_key[c*KW +: KW]);
        dlog.push_back('{c: cyc, core: c, k: k});
        n_issued++;
        if (k < NKEYS) issued[k]++;
        else above_max++;
        if (k > max_issued) max_issued = k;
      end
    end
    if (!rdy) seen_busy = 1;
    if (rdy && seen_busy && rdy_cyc < 0) rdy_cyc = cyc;
  endtask

  task automatic core_react();
    for (int c = 0; c < NC; c++) begin
      if (e_en[c]) begin
        int lat;
        lat = (lat_fixed[c] != 0) ? lat_fixed[c] : int'($urandom_range(1, 6));
        c_start[c] = cyc;
        c_done[c]  = cyc + 1 + lat;
        c_res[c]   = (m_next == fk0) || (m_next == fk1) ||
                     (p_found > 0 && int'($urandom_range(0, 99)) < p_found);
      end
      if (e_abort[c]) begin
        int nd;
        nd = cyc + int'($urandom_range(1, 2));
        if (nd < c_done[c]) c_done[c] = nd;
        c_res[c] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic model_update();
    int  was;
    bit  any, last;
    was  = m_state;
    any  = 0;
    last = 0;
    for (int c = 0; c < NC; c++) begin
      if (e_comp[c]) m_busy[c] = 0;
      m_just[c] = e_en[c];
    end
    if (e_disp) begin
      m_busy[e_didx] = 1;
      m_ckey[e_didx] = m_next;
      last           = (m_next == int'(KMAX));
      m_next++;
    end
    if (e_find) begin
      m_key   = m_ckey[e_fidx];
      m_valid = 1;
    end
    for (int c = 0; c < NC; c++) any |= m_busy[c];
    case (was)
      0: if (en) begin
        m_next  = 0;
        m_key   = 0;
        m_valid = 0;
        m_state = 1;
      end
      1: if (e_find || last) m_state = any ? 2 : 0;
      default: if (!any) m_state = 0;
    endcase
  endtask

  // One clock cycle; entered and left at posedge + 1.
  task automatic step(input bit en_v);
    en = en_v;
    drive_cores();
    @(negedge clk);
    model_eval();
    compare();
    core_react();
    if (rst_n) model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input int budget);
    int n;
    clear_obs();
    job_cyc = cyc;
    step(1'b1);
    check("start_rdy", rdy, 1'b0);
    check("start_valid", key_valid, 1'b0);
    check("start_key", key, 0);
    n = 0;
    while (m_state != 0 && n < budget) begin
      step(int'($urandom_range(0, 99)) < en_pct);
      n++;
    end
    check("job_done_rdy", rdy, 1'b1);
    if (dlog.size() > 0) check("job_first_key", dlog[0].k, 0);
  endtask

  task automatic cfg(input int l0, input int l1, input int f0, input int f1,
                     input int pf, input int ep);
    lat_fixed[0] = l0;
    lat_fixed[1] = l1;
    fk0          = f0;
    fk1          = f1;
    p_found      = pf;
    en_pct       = ep;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_core_en", core_en, '0);
    check("rst_key", key, 0);
    check("rst_core_key", core_key, '0);
    step(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    core_rdy   = '0;
    core_found = '0;
    cores_off  = 0;
    model_reset();
    core_reset();
    clear_obs();
    cfg(0, 0, -1, -1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("init_rdy", rdy, 1'b1);
    check("init_key", key, 0);
    check("init_valid", key_valid, 1'b0);
    check("init_core_en", core_en, '0);
    check("init_core_key", core_key, '0);
    rst_n = 1'b1;
    step(1'b0);

    // Two cores, 6-cycle jobs, key 0x18 is the answer.
    cfg(6, 6, 24'h18, -1, 0, 0);
    run_job(2000);
    check("t1_key", key, 24'h000018);
    check("t1_valid", key_valid, 1'b1);
    check("t1_model_key", m_key, 24'h18);
    check("t1_dlog_ge2", dlog.size() >= 2, 1'b1);
    if (dlog.size() >= 2) begin
      check("t1_first_lat", dlog[0].c - job_cyc, 1);
      check("t1_first_core", dlog[0].core, 0);
      check("t1_first_key", dlog[0].k, 0);
      check("t1_second_lat", dlog[1].c - job_cyc, 2);
      check("t1_second_core", dlog[1].core, 1);
      check("t1_second_key", dlog[1].k, 1);
    end
    for (int k = 0; k < NKEYS; k++) check($sformatf("t1_issued_%0d", k), issued[k], (k <= 'h19));

    // en pulses while busy are ignored; the result is the same.
    cfg(6, 6, 24'h18, -1, 0, 40);
    run_job(2000);
    check("t2_key", key, 24'h000018);
    check("t2_valid", key_valid, 1'b1);
    check("t2_issued", n_issued, 26);

    // No answer: whole (shortened) key space is issued exactly once.
    cfg(0, 0, -1, -1, 0, 10);
    run_job(3000);
    check("t3_n_issued", n_issued, NKEYS);
    check("t3_above_max", above_max, 0);
    check("t3_max_issued", max_issued, 'h3F);
    check("t3_valid", key_valid, 1'b0);
    check("t3_key", key, 0);
    check("t3_model_valid", m_valid, 1'b0);

    // Both cores complete together with a find; core 0 (key 0x20) wins.
    cfg(7, 6, 24'h20, 24'h21, 0, 0);
    run_job(2000);
    check("t4_key", key, 24'h000020);
    check("t4_valid", key_valid, 1'b1);
    check("t4_model_key", m_key, 24'h20);

    // Reset mid-dispatch with no cores responding, then a normal job.
    cores_off = 1;
    cfg(0, 0, -1, -1, 0, 0);
    clear_obs();
    step(1'b1);
    repeat (3) step(1'b0);
    check("t5_mid_rdy", rdy, 1'b0);
    reset_now();
    cores_off = 0;
    cfg(0, 0, 24'h07, -1, 0, 10);
    run_job(2000);
    check("t5_key", key, 24'h000007);

    // Reset while cores are in flight, then restart.
    cfg(0, 0, -1, -1, 0, 0);
    clear_obs();
    step(1'b1);
    repeat (int'($urandom_range(5, 30))) step(1'b0);
    reset_now();
    cfg(0, 0, 24'h2A, -1, 0, 10);
    run_job(2000);
    check("t6_key", key, 24'h00002A);
    check("t6_valid", key_valid, 1'b1);

`ifdef CRACK_SCHED_ABORT_EN
    // Core 0 finds key 0 while core 1 is on a long job: core 1 is aborted.
    cfg(6, 20, 0, -1, 0, 0);
    run_job(2000);
    check("t7_key", key, 0);
    check("t7_valid", key_valid, 1'b1);
    check("t7_abort_cnt", abort_cnt, 1);
    check("t7_abort_val", abort_val, 2'b10);
    check("t7_rdy_within_3", (rdy_cyc >= 0) && (rdy_cyc - abort_cyc <= 3), 1'b1);
`endif

    // Random latencies, random finds, stray en pulses.
    for (int j = 0; j < 12; j++) begin
      cfg(0, 0, -1, -1, int'($urandom_range(0, 6)), 10);
      run_job(3000);
    end

    repeat (2) step(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crack_key_scheduler.md
Name: crack_key_scheduler

Overview:
- Sequences a pool of NCORES ARC4 crack cores over the 24-bit key space.
- On start, issues candidate keys in ascending order to whichever core is idle, one key per core per job.
- Collects per-key results and stops on the first key that yields printable plaintext.
- Sits between the top-level task control (start, HEX key display) and the crack cores, replacing hard-wired per-core key striding.

Parameters:
- NCORES, 2, number of crack cores managed (1..8).
- KEY_W, 24, key width in bits.
- KEY_MAX, 24'hFFFFFF, last candidate key issued (inclusive).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start pulse; sampled only while rdy=1.
- rdy  output  1  high when idle and ready to accept en.
- key  output  KEY_W  winning key; held until next accepted en.
- key_valid  output  1  1 = key found; 0 = key space exhausted; held until next accepted en.
- core_en  output  NCORES  one-cycle start pulse per core.
- core_key  output  NCORES*KEY_W  candidate key per core, slice i = bits [i*KEY_W +: KEY_W]; stable while core busy.
- core_rdy  input  NCORES  core idle/finished.
- core_found  input  NCORES  core result, valid while core_rdy[i]=1 after a job.

Behaviour:
- Reset (async, rst_n=0):
  - rdy=1, key=0, key_valid=0, core_en=0, core_key=0.
  - busy bitmap=0, next_key=0, state IDLE.
  - Applies immediately mid-operation; in-flight core jobs are forgotten.
- Handshake: en honoured only when rdy=1; en with rdy=0 is ignored.
- States:
  - IDLE: rdy=1. On en: next_key=0, key_valid=0, key=0 → DISPATCH. rdy drops the cycle after en.
  - DISPATCH: each cycle, at most one dispatch, to the lowest-index core i with busy[i]=0 and core_rdy[i]=1. That cycle: core_en[i]=1, core_key[i]=next_key, busy[i]=1, next_key+1.
    - First core_en occurs the cycle after en is accepted.
    - After issuing KEY_MAX (no wrap; next_key compare done at KEY_W+1 bits) → DRAIN.
  - DRAIN: no dispatches. When busy=0 → IDLE (rdy=1 that cycle).
- Completion: core i completes when busy[i]=1 and core_rdy[i]=1, excluding the cycle immediately after its core_en (cores drop rdy one cycle after en). On completion, busy[i] clears.
- Found:
  - A completion with core_found[i]=1 while key_valid=0 latches key=core_key[i], key_valid=1.
  - From DISPATCH, it forces DRAIN.
  - Several finds in one cycle: lowest index wins.
  - Finds after key_valid=1 are ignored.
  - A find during exhaustion drain is accepted.
- Same cycle completion and redispatch of one core is not allowed; the core is eligible for dispatch the following cycle.
- rdy=1 together with key_valid=0 means exhausted; key reads 0.

Optional Feature:
- Macro CRACK_SCHED_ABORT_EN.
- Defined:
  - Adds output core_abort (NCORES).
  - In the cycle a find is latched, core_abort pulses for every other busy core.
  - Aborted cores must return core_rdy within 2 cycles; their core_found is ignored.
  - DRAIN then completes quickly.
- Undefined:
  - Port absent.
  - DRAIN waits for every busy core to finish its job normally.

Test Plan:
- Reset and start, no cores responding: rst_n low mid-DISPATCH → rdy=1, core_en=0, key=0 within the reset cycle; after release, en accepted.
- NCORES=2 behavioural cores (6-cycle latency, found iff key==24'h000018): en → core_en[0] with key 0 one cycle later, core_en[1] with key 1 the next cycle; finish with rdy=1, key=24'h000018, key_valid=1, keys 0..0x19 each issued exactly once.
- KEY_MAX=24'h00001F, no key found → exactly 32 dispatches, then rdy=1, key_valid=0, key=0, no key above 0x1F issued.
- Tie: both cores complete in the same cycle with core_found=1 on keys 0x20 (core 0) and 0x21 (core 1) → key=24'h000020.
- en pulsed while rdy=0 → ignored, job result unchanged. Second en after completion → key_valid cleared, search restarts at key 0.
- With CRACK_SCHED_ABORT_EN: found on core 0 while core 1 busy → core_abort=2'b10 for one cycle, rdy=1 within 3 cycles of the find.
